// File: rtl/sparse_buf_pkg.sv
// Shared types for the sparse read buffer drain path.
// Slot geometry, drain policy and output FIFO entry.
package sparse_buf_pkg;

  localparam int SLOTS  = 8;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic {
    DRAIN_INORDER = 1'b0,
    DRAIN_RR      = 1'b1
  } drain_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  slot;
  } drain_entry_t;

endpackage

// File: rtl/sparse_drain_scheduler_if.sv
// Drained-entry stream towards the cache fill logic.
// Plain valid/ready handshake.
interface sparse_drain_scheduler_if;
  import sparse_buf_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PTR_W-1:0]  out_slot;

  modport master (
    output out_valid,
    output out_data,
    output out_slot,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_slot,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo_ff.sv
// Flop-based synchronous FIFO, head read straight from storage.
// Accepts a push while full when a pop happens the same cycle.
module sync_fifo_ff #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  T                             wdata,
  input  logic                         pop,
  output T                             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sparse_drain_scheduler.sv
// Picks one valid sparse-buffer slot per cycle, reads it and
// forwards {data, slot} through a small FIFO to the fill logic.
module sparse_drain_scheduler
  import sparse_buf_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SLOTS-1:0]     sb_valid,
  input  logic [PTR_W-1:0]     sb_bottom_ptr,
  output logic                 sb_read_valid,
  output logic [PTR_W-1:0]     sb_read_ptr,
  output logic                 sb_read_rtn_enable,
  input  logic                 sb_read_rtn_valid,
  input  logic [DATA_W-1:0]    sb_read_rtn_data,
  input  logic                 drain_en,
  input  logic                 mode,
  sparse_drain_scheduler_if.master out_if,
  output logic [CNT_W-1:0]     drained_cnt,
  output logic                 proto_err
);

  localparam int CW = $clog2(OUT_DEPTH+1);

  // Lowest offset after last wins, so last itself is checked last.
  function automatic logic [PTR_W:0] rr_pick(
    logic [SLOTS-1:0] v,
    logic [PTR_W-1:0] last
  );
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   r;
    r = '0;
    for (int i = SLOTS; i >= 1; i--) begin
      idx = last + PTR_W'(i);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  drain_mode_e      mode_e;
  logic [PTR_W:0]   rr_res;
  logic [PTR_W-1:0] cand;
  logic             found;
  logic             pop;
  logic             space;
  logic             issue;
  drain_entry_t     push_e;
  drain_entry_t     head;
  logic             fifo_empty;
  logic             fifo_full_unused;
  logic [CW-1:0]    fifo_count;

  logic [PTR_W-1:0] rr_last_q, rr_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perr_q, perr_d;

  assign mode_e = drain_mode_e'(mode);
  assign rr_res = rr_pick(sb_valid, rr_last_q);

  always_comb begin
    cand  = sb_bottom_ptr;
    found = sb_valid[sb_bottom_ptr];
    unique case (mode_e)
      DRAIN_INORDER: begin
        cand  = sb_bottom_ptr;
        found = sb_valid[sb_bottom_ptr];
      end
      DRAIN_RR: begin
        cand  = rr_res[PTR_W-1:0];
        found = rr_res[PTR_W];
      end
    endcase
  end

  always_comb begin
    pop    = out_if.out_valid & out_if.out_ready;
    space  = (fifo_count < CW'(OUT_DEPTH)) | pop;
    // Nothing may leave the buffer while reset is held.
    issue  = rstn & drain_en & found & space;
    push_e = '{data: sb_read_rtn_data, slot: cand};
  end

  assign sb_read_valid      = issue;
  assign sb_read_rtn_enable = issue;
  assign sb_read_ptr        = issue ? cand : '0;

  always_comb begin
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    if (issue) begin
      rr_last_d = cand;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    perr_d = perr_q | (sb_read_rtn_valid != sb_read_valid);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last_q <= PTR_W'(SLOTS-1);
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
    end
  end

  sync_fifo_ff #(
    .T     (drain_entry_t),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (issue),
    .wdata (push_e),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = head.data;
  assign out_if.out_slot  = head.slot;
  assign drained_cnt      = cnt_q;
  assign proto_err        = perr_q;

endmodule

// File: tb/tb_sparse_drain_scheduler.sv
// Bench for sparse_drain_scheduler: buffer model, directed vectors,
// expected {data, slot} queue checked by an output monitor.
module tb_sparse_drain_scheduler;
  import sparse_buf_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [SLOTS-1:0]  sb_valid;
  logic [PTR_W-1:0]  sb_bottom;
  logic [SLOTS-1:0]  set_mask;
  logic              bot_ld;
  logic [PTR_W-1:0]  bot_val;
  logic              drain_en;
  logic              mode;
  logic              force_err;
  logic [DATA_W-1:0] dbase;

  logic              rd_valid, rd_en, rtn_valid;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rtn_data;
  logic [15:0]       cnt;
  logic              perr;

  logic              s_rd_valid, s_rd_en, s_rtn_valid;
  logic [PTR_W-1:0]  s_rd_ptr;
  logic [3:0]        s_cnt;
  logic              s_perr;

  sparse_drain_scheduler_if dif ();
  sparse_drain_scheduler_if sif ();
  assign sif.out_ready = dif.out_ready;

  assign rtn_valid   = rd_valid ^ force_err;
  assign s_rtn_valid = s_rd_valid ^ force_err;
  assign rtn_data    = dbase + DATA_W'(rd_ptr);

  sparse_drain_scheduler #(.OUT_DEPTH(2), .CNT_W(16)) u_dut (
    .clk                (clk),
    .rstn               (rstn),
    .sb_valid           (sb_valid),
    .sb_bottom_ptr      (sb_bottom),
    .sb_read_valid      (rd_valid),
    .sb_read_ptr        (rd_ptr),
    .sb_read_rtn_enable (rd_en),
    .sb_read_rtn_valid  (rtn_valid),
    .sb_read_rtn_data   (rtn_data),
    .drain_en           (drain_en),
    .mode               (mode),
    .out_if             (dif.master),
    .drained_cnt        (cnt),
    .proto_err          (perr)
  );

  sparse_drain_scheduler #(.OUT_DEPTH(2), .CNT_W(4)) u_sat (
    .clk                (clk),
    .rstn               (rstn),
    .sb_valid           (sb_valid),
    .sb_bottom_ptr      (sb_bottom),
    .sb_read_valid      (s_rd_valid),
    .sb_read_ptr        (s_rd_ptr),
    .sb_read_rtn_enable (s_rd_en),
    .sb_read_rtn_valid  (s_rtn_valid),
    .sb_read_rtn_data   (rtn_data),
    .drain_en           (drain_en),
    .mode               (mode),
    .out_if             (sif.master),
    .drained_cnt        (s_cnt),
    .proto_err          (s_perr)
  );

  // Sparse buffer model: slot cleared on read, bottom advances past it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_valid  <= '0;
      sb_bottom <= '0;
    end else begin
      sb_valid <= (sb_valid & ~(rd_en ? (SLOTS'(1) << rd_ptr) : '0))
                  | set_mask;
      if (bot_ld) sb_bottom <= bot_val;
      else if (rd_en && rd_ptr == sb_bottom) sb_bottom <= sb_bottom + 1'b1;
    end
  end

  int n_vec = 0;
  int n_mis = 0;
  drain_entry_t exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic drain_entry_t ex(logic [DATA_W-1:0] d, int s);
    drain_entry_t e;
    e.data = d;
    e.slot = PTR_W'(s);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [SLOTS-1:0] m, int bot);
    set_mask = m;
    bot_ld   = 1'b1;
    bot_val  = PTR_W'(bot);
    tick();
    set_mask = '0;
    bot_ld   = 1'b0;
  endtask

  initial begin : monitor
    drain_entry_t e;
    forever begin
      @(negedge clk);
      if (rstn && dif.out_valid && dif.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_out: slot %0d data %0h, none expected",
                   dif.out_slot, dif.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", dif.out_data, e.data);
          chk("out_slot", dif.out_slot, e.slot);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: bench did not finish, expected to finish");
    $fatal(1);
  end

  initial begin : stim
    set_mask = '0; bot_ld = 0; bot_val = '0;
    drain_en = 0; mode = 0; force_err = 0;
    dbase = 8'h30; dif.out_ready = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", dif.out_valid, 0);
    chk("rst_out_data", dif.out_data, 0);
    chk("rst_out_slot", dif.out_slot, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_perr", perr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rstn = 1;
    tick();

    // In-order drain from bottom=2
    exp_q.push_back(ex(8'h32, 2));
    exp_q.push_back(ex(8'h33, 3));
    dif.out_ready = 1;
    load(8'h0C, 2);
    chk("drain_en_low", rd_valid, 0);
    drain_en = 1;
    #1;
    chk("io_rv0", rd_valid, 1);
    chk("io_ptr0", rd_ptr, 2);
    tick();
    chk("io_ptr1", rd_ptr, 3);
    chk("io_en1", rd_en, 1);
    tick();
    chk("io_idle", rd_valid, 0);
    tick();
    chk("io_cnt", cnt, 2);

    // Round-robin from a fresh reset
    rstn = 0; tick(); rstn = 1; tick();
    mode = 1; dbase = 8'h40;
    exp_q.push_back(ex(8'h40, 0));
    exp_q.push_back(ex(8'h44, 4));
    exp_q.push_back(ex(8'h47, 7));
    load(8'h91, 0);
    chk("rr_ptr0", rd_ptr, 0);
    tick();
    chk("rr_ptr4", rd_ptr, 4);
    tick();
    chk("rr_ptr7", rd_ptr, 7);
    tick();
    chk("rr_idle", rd_valid, 0);
    exp_q.push_back(ex(8'h40, 0));
    load(8'h01, 0);
    chk("rr_wrap_rv", rd_valid, 1);
    chk("rr_wrap_ptr", rd_ptr, 0);
    repeat (3) tick();

    // Backpressure: only two issues fit
    dif.out_ready = 0; dbase = 8'h50;
    exp_q.push_back(ex(8'h51, 1));
    exp_q.push_back(ex(8'h52, 2));
    exp_q.push_back(ex(8'h53, 3));
    load(8'h0E, 0);
    chk("bp_rv1", rd_valid, 1);
    chk("bp_ptr1", rd_ptr, 1);
    tick();
    chk("bp_rv2", rd_valid, 1);
    chk("bp_ptr2", rd_ptr, 2);
    tick();
    chk("bp_stall", rd_valid, 0);
    chk("bp_held", sb_valid, 8'h08);
    chk("bp_data", dif.out_data, 8'h51);
    chk("bp_slot", dif.out_slot, 1);
    tick();
    chk("bp_stall2", rd_valid, 0);
    chk("bp_data_hold", dif.out_data, 8'h51);
    chk("bp_slot_hold", dif.out_slot, 1);
    dif.out_ready = 1;
    #1;
    chk("bp_resume_rv", rd_valid, 1);
    chk("bp_resume_ptr", rd_ptr, 3);
    repeat (4) tick();
    chk("bp_drained", dif.out_valid, 0);

    // In-order hole, then round-robin on the same map
    mode = 0; dbase = 8'h60;
    load(8'h40, 5);
    chk("hole_inorder", rd_valid, 0);
    tick();
    chk("hole_inorder2", rd_valid, 0);
    exp_q.push_back(ex(8'h66, 6));
    mode = 1;
    #1;
    chk("hole_rr_rv", rd_valid, 1);
    chk("hole_rr_ptr", rd_ptr, 6);
    repeat (3) tick();

    // Protocol error is sticky
    force_err = 1;
    #1;
    chk("perr_pre", perr, 0);
    tick();
    force_err = 0;
    chk("perr_set", perr, 1);
    repeat (2) tick();
    chk("perr_sticky", perr, 1);

    // Asynchronous reset mid-stream
    dif.out_ready = 0; dbase = 8'h70;
    load(8'h03, 0);
    repeat (2) tick();
    chk("mid_pre_valid", dif.out_valid, 1);
    #2;
    rstn = 0;
    #1;
    chk("mid_out_valid", dif.out_valid, 0);
    chk("mid_cnt", cnt, 0);
    chk("mid_perr", perr, 0);
    chk("mid_rd_valid", rd_valid, 0);
    tick();
    rstn = 1;
    tick();

    // 20 drains: wide counter counts, 4-bit counter saturates
    dif.out_ready = 1; mode = 1; dbase = 8'h80;
    for (int r = 0; r < 3; r++) begin
      logic [SLOTS-1:0] m;
      m = (r == 2) ? 8'h0F : 8'hFF;
      for (int s = 0; s < SLOTS; s++)
        if (m[s]) exp_q.push_back(ex(8'h80 + DATA_W'(s), s));
      load(m, 0);
      repeat (9) tick();
    end
    chk("sat_cnt16", cnt, 20);
    chk("sat_cnt4", s_cnt, 15);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
